switch_allocator: RTL and testbench
===================================

Name: switch_allocator

Overview:
- Per-router output-port allocator for the wormhole mesh NoC.
- Takes each input port's route result (from route computation) plus its head/tail flags and shares the 5 output ports (LOCAL, NORTH, SOUTH, WEST, EAST) among the 5 inputs.
- Round-robin arbitration at each output, held for the whole packet from head grant to tail grant.
- Drives input grants and crossbar select lines.

Parameters:
- PORT_NUM, 5, number of router input and output ports.
- PORT_SIZE, 3, width of one inout_Port encoding. Encoding is LOCAL=0, NORTH=1, SOUTH=2, WEST=3, EAST=4, per params_noc.

Ports:
- clk  input  1  single clock for the block.
- rst  input  1  reset; asynchronous, active-high.
- req_Valid  input  PORT_NUM  input i has a flit waiting.
- req_Port  input  PORT_NUM*PORT_SIZE  requested output for input i, at [i*PORT_SIZE +: PORT_SIZE].
- req_Head  input  PORT_NUM  flit at input i is a head flit.
- req_Tail  input  PORT_NUM  flit at input i is a tail flit. A single-flit packet has head and tail both set.
- out_Ready  input  PORT_NUM  downstream of output o can accept a flit this cycle.
- grant  output  PORT_NUM  input i's flit is transferred this cycle.
- out_Valid  output  PORT_NUM  output o carries a flit this cycle.
- xbar_Sel  output  PORT_NUM*PORT_SIZE  input index driving output o, at [o*PORT_SIZE +: PORT_SIZE].
- err_Protocol  output  1  sticky protocol-violation flag.

Behaviour:
- State per output o: fsm[o] in {IDLE, LOCKED}, owner[o] (PORT_SIZE bits), rr_Ptr[o] (PORT_SIZE bits). All are registered.
- Combinational outputs:
  - grant, out_Valid and xbar_Sel are combinational from current state and inputs; zero-cycle allocation latency.
  - While rst=1: grant=0, out_Valid=0, xbar_Sel=0.
- Reset values: fsm=IDLE, owner=0, rr_Ptr=0, err_Protocol=0. Reset mid-packet drops all locks immediately; there is no tail cleanup.
- IDLE at output o:
  - Candidates are inputs i with req_Valid[i], req_Head[i], req_Port(i)==o, and i not owner of any LOCKED output.
  - Winner is the first candidate scanning i = rr_Ptr[o], rr_Ptr[o]+1, ... modulo PORT_NUM.
  - If a winner exists and out_Ready[o]=1:
    - grant[winner]=1, out_Valid[o]=1, xbar_Sel[o]=winner.
    - rr_Ptr[o] <= (winner+1) mod PORT_NUM.
    - If req_Tail[winner]=0: fsm <= LOCKED, owner <= winner.
    - If req_Tail[winner]=1: stay IDLE.
  - If out_Ready[o]=0: no grant; fsm and rr_Ptr are held.
- LOCKED at output o:
  - Only owner[o] is eligible. req_Port and req_Head of the owner are ignored; body flits carry no route.
  - If req_Valid[owner] and out_Ready[o]: grant[owner]=1, out_Valid[o]=1, xbar_Sel[o]=owner.
  - If that flit has req_Tail=1: fsm <= IDLE. rr_Ptr does not change.
  - If the owner is not valid, or out_Ready=0: hold state, no grant. This is a bubble, not an error.
- Tail-grant cycle: a new head for the same output is not considered in the same cycle. It arbitrates next cycle (one-cycle turnaround, decided).
- Independence: outputs allocate independently. An input can win at most one output per cycle because it requests exactly one.
- err_Protocol is set (sticky until rst) on any of the following. The offending flit is never granted.
  - A valid non-head flit from an input that owns no lock.
  - A valid head with req_Port >= PORT_NUM.
  - A valid head (req_Head=1) from an input currently owning a lock.
- Width rules:
  - Port indices are compared as unsigned PORT_SIZE-bit values.
  - rr_Ptr wraps from PORT_NUM-1 to 0.

Test Plan:
- After reset, input 2 sends a head+tail flit to EAST(4) with out_Ready=all 1 → same cycle grant=00100, out_Valid=10000, xbar_Sel[EAST]=2. fsm stays IDLE; next cycle rr_Ptr[EAST]=3.
- Inputs 0, 1, 3 each send single-flit heads to NORTH every cycle for 6 cycles → grant order 0,1,3,0,1,3, one grant per cycle, out_Valid[NORTH]=1 each cycle.
- Input 1 sends a 4-flit packet (head, 2 body, tail) to SOUTH while input 4 holds a head to SOUTH:
  - Input 1 is granted 4 consecutive cycles; input 4 is blocked.
  - Input 4 is granted on the cycle after the tail grant.
- Packet locked on WEST, out_Ready[WEST]=0 for 3 cycles mid-packet → no grants, state held, err_Protocol=0. Resumes when out_Ready returns to 1.
- Body flit valid from an input with no lock, then a head with req_Port=6 → neither granted; err_Protocol=1 and held until rst.
- rst asserted asynchronously mid-packet (LOCKED on EAST) → grant/out_Valid drop to 0 immediately. After release, a fresh head to EAST from another input is granted, rr_Ptr starting from 0.

Source files
------------

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: per-output round-robin arbitration with
// packet-long locks, driving input grants and crossbar selects.
module switch_allocator #(
  parameter int PORT_NUM  = 5,
  parameter int PORT_SIZE = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORT_NUM-1:0]           req_Valid,
  input  logic [PORT_NUM*PORT_SIZE-1:0] req_Port,
  input  logic [PORT_NUM-1:0]           req_Head,
  input  logic [PORT_NUM-1:0]           req_Tail,
  input  logic [PORT_NUM-1:0]           out_Ready,
  output logic [PORT_NUM-1:0]           grant,
  output logic [PORT_NUM-1:0]           out_Valid,
  output logic [PORT_NUM*PORT_SIZE-1:0] xbar_Sel,
  output logic                          err_Protocol
);

  typedef enum logic {IDLE, LOCKED} state_t;
  typedef logic [PORT_SIZE-1:0] idx_t;

  state_t fsm       [PORT_NUM];
  state_t fsm_nxt   [PORT_NUM];
  idx_t   owner     [PORT_NUM];
  idx_t   owner_nxt [PORT_NUM];
  idx_t   rr_ptr    [PORT_NUM];
  idx_t   rr_nxt    [PORT_NUM];

  logic [PORT_NUM-1:0] owns;
  logic [PORT_NUM-1:0] cand [PORT_NUM];
  logic                viol;

  // Inputs currently holding a lock on some output
  always_comb begin
    owns = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int i = 0; i < PORT_NUM; i++) begin
        if (fsm[o] == LOCKED && owner[o] == idx_t'(i))
          owns[i] = 1'b1;
      end
    end
  end

  always_comb begin
    viol = 1'b0;
    for (int o = 0; o < PORT_NUM; o++) begin
      cand[o] = '0;
    end
    for (int i = 0; i < PORT_NUM; i++) begin
      for (int o = 0; o < PORT_NUM; o++) begin
        if (req_Valid[i] && req_Head[i] && !owns[i] &&
            req_Port[i*PORT_SIZE +: PORT_SIZE] == idx_t'(o))
          cand[o][i] = 1'b1;
      end
      if (req_Valid[i]) begin
        if (!req_Head[i] && !owns[i])
          viol = 1'b1;
        if (req_Head[i] && owns[i])
          viol = 1'b1;
        if (req_Head[i] &&
            {1'b0, req_Port[i*PORT_SIZE +: PORT_SIZE]} >=
            (PORT_SIZE+1)'(PORT_NUM))
          viol = 1'b1;
      end
    end
  end

  always_comb begin
    logic found;
    int   win;
    int   idx;
    grant     = '0;
    out_Valid = '0;
    xbar_Sel  = '0;
    found     = 1'b0;
    win       = 0;
    idx       = 0;
    for (int o = 0; o < PORT_NUM; o++) begin
      fsm_nxt[o]   = fsm[o];
      owner_nxt[o] = owner[o];
      rr_nxt[o]    = rr_ptr[o];
    end
    for (int o = 0; o < PORT_NUM; o++) begin
      if (fsm[o] == LOCKED) begin
        // A head from the owner is a protocol error and is never granted
        for (int i = 0; i < PORT_NUM; i++) begin
          if (owner[o] == idx_t'(i) && req_Valid[i] &&
              !req_Head[i] && out_Ready[o]) begin
            grant[i]     = 1'b1;
            out_Valid[o] = 1'b1;
            xbar_Sel[o*PORT_SIZE +: PORT_SIZE] = owner[o];
            if (req_Tail[i])
              fsm_nxt[o] = IDLE;
          end
        end
      end else begin
        found = 1'b0;
        win   = 0;
        for (int k = 0; k < PORT_NUM; k++) begin
          idx = (int'(rr_ptr[o]) + k) % PORT_NUM;
          if (!found && cand[o][idx]) begin
            found = 1'b1;
            win   = idx;
          end
        end
        if (found && out_Ready[o]) begin
          grant[win]   = 1'b1;
          out_Valid[o] = 1'b1;
          xbar_Sel[o*PORT_SIZE +: PORT_SIZE] = idx_t'(win);
          rr_nxt[o] = idx_t'((win + 1) % PORT_NUM);
          if (!req_Tail[win]) begin
            fsm_nxt[o]   = LOCKED;
            owner_nxt[o] = idx_t'(win);
          end
        end
      end
    end
    if (rst) begin
      grant     = '0;
      out_Valid = '0;
      xbar_Sel  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < PORT_NUM; o++) begin
        fsm[o]    <= IDLE;
        owner[o]  <= '0;
        rr_ptr[o] <= '0;
      end
      err_Protocol <= 1'b0;
    end else begin
      for (int o = 0; o < PORT_NUM; o++) begin
        fsm[o]    <= fsm_nxt[o];
        owner[o]  <= owner_nxt[o];
        rr_ptr[o] <= rr_nxt[o];
      end
      err_Protocol <= err_Protocol | viol;
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: cycle-by-cycle vector table plus
// hand-driven error and asynchronous-reset sequences.
module tb_switch_allocator;

  logic        clk;
  logic        rst;
  logic [4:0]  req_Valid;
  logic [14:0] req_Port;
  logic [4:0]  req_Head;
  logic [4:0]  req_Tail;
  logic [4:0]  out_Ready;
  logic [4:0]  grant;
  logic [4:0]  out_Valid;
  logic [14:0] xbar_Sel;
  logic        err_Protocol;

  int total = 0;
  int bad   = 0;

  switch_allocator #(.PORT_NUM(5), .PORT_SIZE(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_Valid    (req_Valid),
    .req_Port     (req_Port),
    .req_Head     (req_Head),
    .req_Tail     (req_Tail),
    .out_Ready    (out_Ready),
    .grant        (grant),
    .out_Valid    (out_Valid),
    .xbar_Sel     (xbar_Sel),
    .err_Protocol (err_Protocol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  v;
    logic [14:0] p;
    logic [4:0]  h;
    logic [4:0]  t;
    logic [4:0]  r;
    logic [4:0]  g;
    logic [4:0]  ov;
    logic [14:0] xs;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [14:0] pk(input int a0, input int a1,
                                     input int a2, input int a3,
                                     input int a4);
    return {3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  task automatic add(input logic [4:0] v, input logic [14:0] p,
                     input logic [4:0] h, input logic [4:0] t,
                     input logic [4:0] r, input logic [4:0] g,
                     input logic [4:0] ov, input logic [14:0] xs);
    vec_t e;
    e.v = v; e.p = p; e.h = h; e.t = t; e.r = r;
    e.g = g; e.ov = ov; e.xs = xs;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] v, input logic [14:0] p,
                       input logic [4:0] h, input logic [4:0] t,
                       input logic [4:0] r);
    req_Valid = v; req_Port = p; req_Head = h;
    req_Tail = t; out_Ready = r;
  endtask

  localparam logic [4:0] R = 5'b11111;
  int nw[6] = '{1, 2, 8, 1, 2, 8};
  int nx[6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    // single flits: EAST, then rr wrap check on EAST
    add(5'b00100, pk(0,0,4,0,0), 5'b00100, 5'b00100, R,
        5'b00100, 5'b10000, pk(0,0,0,0,2));
    add(5'b10001, pk(4,0,0,0,4), 5'b10001, 5'b10001, R,
        5'b10000, 5'b10000, pk(0,0,0,0,4));
    add(5'b10001, pk(4,0,0,0,4), 5'b10001, 5'b10001, R,
        5'b00001, 5'b10000, pk(0,0,0,0,0));
    // three inputs competing for NORTH
    for (int k = 0; k < 6; k++)
      add(5'b01011, pk(1,1,0,1,0), 5'b01011, 5'b01011, R,
          5'(nw[k]), 5'b00010, pk(0,nx[k],0,0,0));
    // 4-flit packet on SOUTH blocks input 4
    add(5'b10010, pk(0,2,0,0,2), 5'b10010, 5'b10000, R,
        5'b00010, 5'b00100, pk(0,0,1,0,0));
    add(5'b10010, pk(0,0,0,0,2), 5'b10000, 5'b10000, R,
        5'b00010, 5'b00100, pk(0,0,1,0,0));
    add(5'b10010, pk(0,0,0,0,2), 5'b10000, 5'b10000, R,
        5'b00010, 5'b00100, pk(0,0,1,0,0));
    add(5'b10010, pk(0,0,0,0,2), 5'b10000, 5'b10010, R,
        5'b00010, 5'b00100, pk(0,0,1,0,0));
    add(5'b10000, pk(0,0,0,0,2), 5'b10000, 5'b10000, R,
        5'b10000, 5'b00100, pk(0,0,4,0,0));
    // WEST packet with downstream stall
    add(5'b00001, pk(3,0,0,0,0), 5'b00001, 5'b00000, R,
        5'b00001, 5'b01000, pk(0,0,0,0,0));
    for (int k = 0; k < 3; k++)
      add(5'b00001, pk(0,0,0,0,0), 5'b00000, 5'b00000, 5'b10111,
          5'b00000, 5'b00000, pk(0,0,0,0,0));
    add(5'b00001, pk(0,0,0,0,0), 5'b00000, 5'b00000, R,
        5'b00001, 5'b01000, pk(0,0,0,0,0));
    add(5'b00001, pk(0,0,0,0,0), 5'b00000, 5'b00001, R,
        5'b00001, 5'b01000, pk(0,0,0,0,0));
    // LOCAL not ready, then ready
    add(5'b01000, pk(0,0,0,0,0), 5'b01000, 5'b01000, 5'b11110,
        5'b00000, 5'b00000, pk(0,0,0,0,0));
    add(5'b01000, pk(0,0,0,0,0), 5'b01000, 5'b01000, R,
        5'b01000, 5'b00001, pk(3,0,0,0,0));
    // two outputs allocated in the same cycle
    add(5'b00011, pk(4,1,0,0,0), 5'b00011, 5'b00011, R,
        5'b00011, 5'b10010, pk(0,1,0,0,0));

    // reset: outputs gated even with a valid request present
    rst = 1'b1;
    drive(5'b00100, pk(0,0,4,0,0), 5'b00100, 5'b00100, R);
    #2;
    chk("rst_outputs", {grant, out_Valid, xbar_Sel}, 25'd0);
    chk("rst_err", err_Protocol, 0);
    drive(0, 0, 0, 0, R);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[n]) begin
      @(negedge clk);
      drive(tbl[n].v, tbl[n].p, tbl[n].h, tbl[n].t, tbl[n].r);
      #1;
      chk($sformatf("vec%0d", n),
          {grant, out_Valid, xbar_Sel, err_Protocol},
          {tbl[n].g, tbl[n].ov, tbl[n].xs, 1'b0});
    end

    // body flit from an input without a lock
    @(negedge clk);
    drive(5'b00100, pk(0,0,0,0,0), 5'b00000, 5'b00000, R);
    #1;
    chk("orphan_body_grant", {grant, out_Valid}, 10'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, R);
    #1;
    chk("orphan_body_err", err_Protocol, 1);
    #2 rst = 1'b1;
    #1;
    chk("err_cleared", err_Protocol, 0);
    @(negedge clk);
    rst = 1'b0;

    // head with out-of-range port
    @(negedge clk);
    drive(5'b01000, pk(0,0,0,6,0), 5'b01000, 5'b01000, R);
    #1;
    chk("bad_port_grant", {grant, out_Valid}, 10'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, R);
    repeat (3) @(negedge clk);
    #1;
    chk("bad_port_err_sticky", err_Protocol, 1);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("err_reset", err_Protocol, 0);

    // async reset while locked on EAST
    @(negedge clk);
    drive(5'b00010, pk(0,4,0,0,0), 5'b00010, 5'b00000, R);
    #1;
    chk("east_head", {grant, out_Valid, xbar_Sel},
        {5'b00010, 5'b10000, pk(0,0,0,0,1)});
    @(negedge clk);
    drive(5'b00010, pk(0,0,0,0,0), 5'b00000, 5'b00000, R);
    #1;
    chk("east_body", {grant, out_Valid}, {5'b00010, 5'b10000});
    #1 rst = 1'b1;
    #1;
    chk("async_rst_drop", {grant, out_Valid, xbar_Sel}, 25'd0);
    @(negedge clk);
    drive(5'b01001, pk(4,0,0,4,0), 5'b01001, 5'b01001, R);
    rst = 1'b0;
    #1;
    chk("post_rst_rr0", {grant, out_Valid, xbar_Sel},
        {5'b00001, 5'b10000, pk(0,0,0,0,0)});
    chk("post_rst_err", err_Protocol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
